// File: rtl/pll_reset_sequencer.sv
// Lock-qualified reset sequencer: synchronises and filters the PLL lock flag, then
// releases NUM_CHANNELS active-low domain resets in a staggered order.
module pll_reset_sequencer #(
    parameter int NUM_CHANNELS       = 3,
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int STAGGER_CYCLES     = 4,
    parameter int SYNC_STAGES        = 2,
    parameter int CNT_WIDTH          = 8
) (
    input  logic                    clock_in,
    input  logic                    reset_n,
    input  logic                    locked,
    input  logic                    sw_reset_req,
    output logic [NUM_CHANNELS-1:0] rst_n_out,
    output logic                    ready,
    output logic [1:0]              state_o,
    output logic [CNT_WIDTH-1:0]    loss_count
);

    localparam int LAST_STG = (NUM_CHANNELS - 1) * STAGGER_CYCLES;
    localparam int STG_W    = $clog2(LAST_STG + 2);
    localparam int STB_W    = $clog2(LOCK_STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    lock_sync_s;
    logic [STB_W-1:0]        stb_q, stb_d;
    logic [STG_W-1:0]        stg_q, stg_d, stg_inc_s;
    logic [NUM_CHANNELS-1:0] rst_q, rst_d;
    logic                    ready_q, ready_d;
    logic [CNT_WIDTH-1:0]    loss_q, loss_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_WIDTH'(1);
        end
    endfunction

    assign lock_sync_s = sync_q[SYNC_STAGES-1];

    // Lock flag synchroniser shift register.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_LOCK;
            stb_q   <= {STB_W{1'b0}};
            stg_q   <= {STG_W{1'b0}};
            rst_q   <= {NUM_CHANNELS{1'b0}};
            ready_q <= 1'b0;
            loss_q  <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            stg_q   <= stg_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            loss_q  <= loss_d;
        end
    end

    // Next-state logic; lock loss outranks a software request.
    always_comb begin
        state_d   = state_q;
        stb_d     = stb_q;
        stg_d     = stg_q;
        rst_d     = rst_q;
        ready_d   = ready_q;
        loss_d    = loss_q;
        stg_inc_s = stg_q + STG_W'(1);
        case (state_q)
            WAIT_LOCK: begin
                stb_d = {STB_W{1'b0}};
                if (lock_sync_s) begin
                    state_d = STABLE;
                end else begin
                    state_d = WAIT_LOCK;
                end
            end
            STABLE: begin
                if (!lock_sync_s) begin
                    state_d = WAIT_LOCK;
                    stb_d   = {STB_W{1'b0}};
                end else if (sw_reset_req) begin
                    stb_d = {STB_W{1'b0}};
                end else if (stb_q == STB_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d  = RELEASE;
                    stb_d    = {STB_W{1'b0}};
                    stg_d    = {STG_W{1'b0}};
                    rst_d[0] = 1'b1;
                end else begin
                    stb_d = stb_q + STB_W'(1);
                end
            end
            RELEASE, RUN: begin
                if (!lock_sync_s) begin
                    state_d = WAIT_LOCK;
                    stb_d   = {STB_W{1'b0}};
                    stg_d   = {STG_W{1'b0}};
                    rst_d   = {NUM_CHANNELS{1'b0}};
                    ready_d = 1'b0;
                    loss_d  = sat_inc(loss_q);
                end else if (sw_reset_req) begin
                    state_d = STABLE;
                    stb_d   = {STB_W{1'b0}};
                    stg_d   = {STG_W{1'b0}};
                    rst_d   = {NUM_CHANNELS{1'b0}};
                    ready_d = 1'b0;
                end else if (state_q == RUN) begin
                    state_d = RUN;
                end else if (stg_q == STG_W'(LAST_STG)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else begin
                    stg_d = stg_inc_s;
                    // Channel k opens when the stagger count lands on k*STAGGER_CYCLES.
                    for (int k = 1; k < NUM_CHANNELS; k++) begin
                        rst_d[k] = rst_q[k] | (stg_inc_s == STG_W'(k * STAGGER_CYCLES));
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                stb_d   = {STB_W{1'b0}};
                stg_d   = {STG_W{1'b0}};
                rst_d   = {NUM_CHANNELS{1'b0}};
                ready_d = 1'b0;
            end
        endcase
    end

    assign rst_n_out  = rst_q;
    assign ready      = ready_q;
    assign state_o    = state_q;
    assign loss_count = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed expectations per edge, a monitor
// process compares them against the DUT outputs on the falling clock edge.
module tb_pll_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       m_rst_n, m_locked, m_sw;
    logic [2:0] m_rst;
    logic       m_rdy;
    logic [1:0] m_st;
    logic [7:0] m_cnt;

    logic       s_rst_n, s_locked, s_sw;
    logic [0:0] s_rst;
    logic       s_rdy;
    logic [1:0] s_st;
    logic [1:0] s_cnt;

    pll_reset_sequencer u_main (
        .clock_in     (clk),
        .reset_n      (m_rst_n),
        .locked       (m_locked),
        .sw_reset_req (m_sw),
        .rst_n_out    (m_rst),
        .ready        (m_rdy),
        .state_o      (m_st),
        .loss_count   (m_cnt)
    );

    pll_reset_sequencer #(
        .NUM_CHANNELS       (1),
        .LOCK_STABLE_CYCLES (2),
        .STAGGER_CYCLES     (1),
        .SYNC_STAGES        (2),
        .CNT_WIDTH          (2)
    ) u_sat (
        .clock_in     (clk),
        .reset_n      (s_rst_n),
        .locked       (s_locked),
        .sw_reset_req (s_sw),
        .rst_n_out    (s_rst),
        .ready        (s_rdy),
        .state_o      (s_st),
        .loss_count   (s_cnt)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         total = 0;
    int         bad   = 0;
    int         q_cyc[$];
    int         q_dut[$];
    logic [2:0] q_rst[$];
    logic       q_rdy[$];
    logic [1:0] q_st[$];
    logic [7:0] q_cnt[$];
    string      q_name[$];

    task automatic expect_at(input int dut, input int c, input logic [2:0] r, input logic y,
                             input logic [1:0] s, input logic [7:0] n, input string nm);
        q_cyc.push_back(c);
        q_dut.push_back(dut);
        q_rst.push_back(r);
        q_rdy.push_back(y);
        q_st.push_back(s);
        q_cnt.push_back(n);
        q_name.push_back(nm);
    endtask

    // Monitor: pops every expectation due at this edge and compares.
    initial begin
        int         c, d;
        logic [2:0] er, ar;
        logic       ey, ay;
        logic [1:0] es, as_;
        logic [7:0] en, an;
        string      nm;
        forever begin
            @(negedge clk);
            while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
                c  = q_cyc.pop_front();
                d  = q_dut.pop_front();
                er = q_rst.pop_front();
                ey = q_rdy.pop_front();
                es = q_st.pop_front();
                en = q_cnt.pop_front();
                nm = q_name.pop_front();
                if (d == 0) begin
                    ar = m_rst; ay = m_rdy; as_ = m_st; an = m_cnt;
                end else begin
                    ar = {2'b00, s_rst}; ay = s_rdy; as_ = s_st; an = {6'd0, s_cnt};
                end
                total++;
                if (c != cyc || ar !== er || ay !== ey || as_ !== es || an !== en) begin
                    bad++;
                    $display("FAIL %s edge=%0d(due %0d): got rst=%b rdy=%b st=%0d cnt=%0d, want rst=%b rdy=%b st=%0d cnt=%0d",
                             nm, cyc, c, ar, ay, as_, an, er, ey, es, en);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t0, t1, t2, t3, t4, t6, t7, s0, b, e;
        m_rst_n = 1'b0; m_locked = 1'b0; m_sw = 1'b0;
        s_rst_n = 1'b0; s_locked = 1'b0; s_sw = 1'b0;
        step(3);
        expect_at(0, cyc, 3'b000, 1'b0, 2'd0, 8'd0, "reset_main");
        expect_at(1, cyc, 3'b000, 1'b0, 2'd0, 8'd0, "reset_sat");
        step(1);

        // Power-up sequence, lock sampled from edge 1.
        t0 = cyc;
        m_rst_n = 1'b1; m_locked = 1'b1;
        expect_at(0, t0 + 2,  3'b000, 1'b0, 2'd0, 8'd0, "sync_wait");
        expect_at(0, t0 + 3,  3'b000, 1'b0, 2'd1, 8'd0, "enter_stable");
        expect_at(0, t0 + 18, 3'b000, 1'b0, 2'd1, 8'd0, "pre_release");
        expect_at(0, t0 + 19, 3'b001, 1'b0, 2'd2, 8'd0, "ch0_edge19");
        expect_at(0, t0 + 22, 3'b001, 1'b0, 2'd2, 8'd0, "ch1_hold");
        expect_at(0, t0 + 23, 3'b011, 1'b0, 2'd2, 8'd0, "ch1_edge23");
        expect_at(0, t0 + 26, 3'b011, 1'b0, 2'd2, 8'd0, "ch2_hold");
        expect_at(0, t0 + 27, 3'b111, 1'b0, 2'd2, 8'd0, "ch2_edge27");
        expect_at(0, t0 + 28, 3'b111, 1'b1, 2'd3, 8'd0, "ready_edge28");

        // Lock loss in RUN.
        goto(t0 + 40);
        m_locked = 1'b0;
        expect_at(0, t0 + 42, 3'b111, 1'b1, 2'd3, 8'd0, "loss_latency");
        expect_at(0, t0 + 43, 3'b000, 1'b0, 2'd0, 8'd1, "loss_edge43");
        goto(t0 + 45);
        t1 = cyc;
        m_locked = 1'b1;
        expect_at(0, t1 + 18, 3'b000, 1'b0, 2'd1, 8'd1, "relock_pre");
        expect_at(0, t1 + 19, 3'b001, 1'b0, 2'd2, 8'd1, "relock_ch0");
        expect_at(0, t1 + 23, 3'b011, 1'b0, 2'd2, 8'd1, "relock_ch1");
        expect_at(0, t1 + 27, 3'b111, 1'b0, 2'd2, 8'd1, "relock_ch2");
        expect_at(0, t1 + 28, 3'b111, 1'b1, 2'd3, 8'd1, "relock_ready");

        // Software request in RUN.
        goto(t1 + 30);
        t2 = cyc;
        expect_at(0, t2 + 1,  3'b000, 1'b0, 2'd1, 8'd1, "sw_abort");
        expect_at(0, t2 + 16, 3'b000, 1'b0, 2'd1, 8'd1, "sw_pre_release");
        expect_at(0, t2 + 17, 3'b001, 1'b0, 2'd2, 8'd1, "sw_ch0_17");
        expect_at(0, t2 + 25, 3'b111, 1'b0, 2'd2, 8'd1, "sw_ch2");
        expect_at(0, t2 + 26, 3'b111, 1'b1, 2'd3, 8'd1, "sw_ready");
        m_sw = 1'b1;
        step(1);
        m_sw = 1'b0;

        // Lock glitch while STABLE counter is at 10.
        goto(t2 + 30);
        t3 = cyc;
        m_locked = 1'b0;
        expect_at(0, t3 + 3, 3'b000, 1'b0, 2'd0, 8'd2, "loss2");
        goto(t3 + 5);
        t4 = cyc;
        m_locked = 1'b1;
        expect_at(0, t4 + 3,  3'b000, 1'b0, 2'd1, 8'd2, "stable_again");
        goto(t4 + 13);
        m_locked = 1'b0;
        expect_at(0, t4 + 13, 3'b000, 1'b0, 2'd1, 8'd2, "stable_cnt10");
        expect_at(0, t4 + 15, 3'b000, 1'b0, 2'd1, 8'd2, "glitch_latency");
        expect_at(0, t4 + 16, 3'b000, 1'b0, 2'd0, 8'd2, "glitch_wait_nocount");
        expect_at(0, t4 + 18, 3'b000, 1'b0, 2'd0, 8'd2, "glitch_still_wait");
        expect_at(0, t4 + 19, 3'b000, 1'b0, 2'd1, 8'd2, "glitch_restable");
        expect_at(0, t4 + 34, 3'b000, 1'b0, 2'd1, 8'd2, "glitch_full16");
        expect_at(0, t4 + 35, 3'b001, 1'b0, 2'd2, 8'd2, "glitch_ch0");
        expect_at(0, t4 + 44, 3'b111, 1'b1, 2'd3, 8'd2, "glitch_ready");
        goto(t4 + 16);
        m_locked = 1'b1;

        // Lock loss and software request on the same edge.
        goto(t4 + 50);
        t6 = cyc;
        m_locked = 1'b0;
        expect_at(0, t6 + 2, 3'b111, 1'b1, 2'd3, 8'd2, "simul_pre");
        expect_at(0, t6 + 3, 3'b000, 1'b0, 2'd0, 8'd3, "simul_loss_wins");
        goto(t6 + 2);
        m_sw = 1'b1;
        step(1);
        m_sw = 1'b0;

        // Asynchronous reset mid-RELEASE.
        goto(t6 + 5);
        t7 = cyc;
        m_locked = 1'b1;
        expect_at(0, t7 + 19, 3'b001, 1'b0, 2'd2, 8'd3, "pre_async_ch0");
        expect_at(0, t7 + 20, 3'b000, 1'b0, 2'd0, 8'd0, "async_reset");
        goto(t7 + 20);
        #1;
        m_rst_n = 1'b0;
        step(2);
        expect_at(0, cyc, 3'b000, 1'b0, 2'd0, 8'd0, "held_in_reset");
        step(1);

        // Single-channel instance: release timing and counter saturation.
        s0 = cyc;
        s_rst_n = 1'b1; s_locked = 1'b1;
        expect_at(1, s0 + 4, 3'b000, 1'b0, 2'd1, 8'd0, "sat_stable");
        expect_at(1, s0 + 5, 3'b001, 1'b0, 2'd2, 8'd0, "sat_release");
        expect_at(1, s0 + 6, 3'b001, 1'b1, 2'd3, 8'd0, "sat_run");
        b = s0 + 8;
        for (int i = 0; i < 5; i++) begin
            e = (i + 1 > 3) ? 3 : i + 1;
            goto(b);
            s_locked = 1'b0;
            expect_at(1, b + 3,  3'b000, 1'b0, 2'd0, 8'(e), "sat_loss");
            expect_at(1, b + 9,  3'b001, 1'b0, 2'd2, 8'(e), "sat_rerelease");
            expect_at(1, b + 10, 3'b001, 1'b1, 2'd3, 8'(e), "sat_rerun");
            goto(b + 4);
            s_locked = 1'b1;
            b = b + 12;
        end

        for (int k = 0; k < 100 && q_cyc.size() > 0; k++) step(1);
        if (q_cyc.size() > 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d expectations never checked, want 0", q_cyc.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
